// File: rtl/multicycle_seq.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32 core.
// Drives the register enables of IFetch, Decoder and MemOrIO, handles
// memory wait states, halt requests and a sticky bus-timeout trap.
// Optional feature macro: PERF_CNT_EN (cycle and instret counters).
module multicycle_seq #(
    parameter int unsigned TO_W        = 4,
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             is_load,
    input  logic             is_store,
    input  logic             reg_write,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             halt_req,
    output logic             imem_re,
    output logic             ir_we,
    output logic             dmem_re,
    output logic             dmem_we,
    output logic             rf_we,
    output logic             pc_we,
    output logic [2:0]       state,
    output logic             timeout_err,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StHalt   = 3'd6,
        StError  = 3'd7
    } state_e;

    localparam logic [TO_W-1:0] TimeoutVal = TO_W'(MEM_TIMEOUT);

    state_e          state_q;
    logic [TO_W-1:0] wait_q;
    logic            timeout_err_q;
    // One-hot phase flags registered alongside the state so the enables come
    // straight from flops; the async reset clears them with the state.
    logic            in_fetch_q;
    logic            in_mem_q;
    logic            in_wb_q;

    // Sequencer FSM: state, wait-state counter, timeout flag and phase flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            wait_q        <= '0;
            timeout_err_q <= 1'b0;
            in_fetch_q    <= 1'b0;
            in_mem_q      <= 1'b0;
            in_wb_q       <= 1'b0;
        end else begin
            in_fetch_q <= 1'b0;
            in_mem_q   <= 1'b0;
            in_wb_q    <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    state_q    <= StFetch;
                    in_fetch_q <= 1'b1;
                end
                StFetch: begin
                    // Ready on the compare cycle wins over the trap.
                    if (imem_ready) begin
                        state_q <= StDecode;
                        wait_q  <= '0;
                    end else if (wait_q == TimeoutVal) begin
                        state_q       <= StError;
                        timeout_err_q <= 1'b1;
                    end else begin
                        wait_q     <= wait_q + TO_W'(1);
                        in_fetch_q <= 1'b1;
                    end
                end
                StDecode: begin
                    state_q <= StExec;
                end
                StExec: begin
                    if (is_load || is_store) begin
                        state_q  <= StMem;
                        in_mem_q <= 1'b1;
                    end else begin
                        state_q <= StWb;
                        in_wb_q <= 1'b1;
                    end
                end
                StMem: begin
                    if (dmem_ready) begin
                        state_q <= StWb;
                        wait_q  <= '0;
                        in_wb_q <= 1'b1;
                    end else if (wait_q == TimeoutVal) begin
                        state_q       <= StError;
                        timeout_err_q <= 1'b1;
                    end else begin
                        wait_q   <= wait_q + TO_W'(1);
                        in_mem_q <= 1'b1;
                    end
                end
                StWb, StHalt: begin
                    if (halt_req) begin
                        state_q <= StHalt;
                    end else begin
                        state_q    <= StFetch;
                        in_fetch_q <= 1'b1;
                    end
                end
                StError: begin
                    state_q <= StError;
                end
            endcase
        end
    end

    // Enables: registered phase flags, qualified by the live handshake and
    // instruction-class inputs where the enable depends on them.
    always_comb begin
        imem_re     = in_fetch_q;
        ir_we       = in_fetch_q & imem_ready;
        dmem_re     = in_mem_q & is_load;
        dmem_we     = in_mem_q & is_store;
        rf_we       = in_wb_q & reg_write;
        pc_we       = in_wb_q;
        state       = state_q;
        timeout_err = timeout_err_q;
    end

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] cycle_q;
    logic [CNT_W-1:0] instret_q;

    // Free-running cycle counter; instret bumps once per WB cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q <= cycle_q + CNT_W'(1);
            if (state_q == StWb) begin
                instret_q <= instret_q + CNT_W'(1);
            end
        end
    end

    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

endmodule
